// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage handshake between the pipeline and the multiply/divide controller.
interface muldiv_ctrl_if;
    logic ismultE, isdivE, signedE, divzeroE, flushE;
    logic mulstart, divstart, signedop, stallmdE, hilovalid, busy, cancel;
    modport master (
        output ismultE, isdivE, signedE, divzeroE, flushE,
        input  mulstart, divstart, signedop, stallmdE, hilovalid, busy, cancel
    );
    modport slave (
        input  ismultE, isdivE, signedE, divzeroE, flushE,
        output mulstart, divstart, signedop, stallmdE, hilovalid, busy, cancel
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences multiply/divide units, stalls EX until HI/LO is ready.
// Define MULDIV_DIVZERO_EN to short-circuit divide-by-zero straight to DONE.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input logic clk,
    input logic rst,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam logic [5:0] MUL_LD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LD = 6'(DIV_LAT - 1);
    state_t r_state, w_next;
    logic [5:0] r_cnt, w_cnt;
    logic r_signed, w_signed, w_acc, w_dz, w_busy, w_run, w_flush;
    always_comb begin
        w_busy = r_state != IDLE;
        w_run = r_state == MUL || r_state == DIV;
        w_flush = w_busy && bus.flushE;
        // Gating with rst keeps the combinational start/stall paths at 0 during reset.
        w_acc = rst && !w_busy && (bus.ismultE || bus.isdivE) && !bus.flushE;
`ifdef MULDIV_DIVZERO_EN
        w_dz = w_acc && bus.isdivE && bus.divzeroE;
`else
        w_dz = 1'b0;
`endif
        w_next = w_flush ? IDLE :
                 !w_busy ? (w_acc ? (w_dz ? DONE : bus.isdivE ? DIV : MUL) : IDLE) :
                 r_state == DONE ? IDLE :
                 r_cnt <= 6'd1 ? DONE : r_state;
        w_cnt = w_acc ? (bus.isdivE ? DIV_LD : MUL_LD) :
                w_next == IDLE ? 6'd0 :
                (w_run && r_cnt != 6'd0) ? r_cnt - 6'd1 : r_cnt;
        w_signed = w_acc ? bus.signedE : (w_next == IDLE ? 1'b0 : r_signed);
        bus.mulstart = w_acc && !bus.isdivE;
        bus.divstart = w_acc && bus.isdivE && !w_dz;
        bus.stallmdE = w_acc || (w_run && !bus.flushE);
        bus.hilovalid = r_state == DONE && !bus.flushE;
        bus.busy = w_busy;
        bus.cancel = w_flush;
        bus.signedop = r_signed;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt <= 6'd0;
            r_signed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt <= w_cnt;
            r_signed <= w_signed;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboarded bench; expected HI/LO cycle is queued at issue and popped on hilovalid.
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;
`ifdef MULDIV_DIVZERO_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errs = 0;
    int checks = 0;
    int exp_q[$];
    muldiv_ctrl_if bus();
    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic idle_inputs();
        bus.ismultE = 0;
        bus.isdivE = 0;
        bus.signedE = 0;
        bus.divzeroE = 0;
        bus.flushE = 0;
    endtask
    function automatic int outs();
        return {bus.mulstart, bus.divstart, bus.signedop, bus.stallmdE, bus.hilovalid, bus.busy, bus.cancel};
    endfunction
    task automatic run_op(input bit m, input bit d, input bit s, input bit dz, input int fl, input bit hold);
        int lat;
        lat = d ? ((DZ && dz) ? 1 : DIV_LAT) : MUL_LAT;
        if (fl < 0 || fl > lat) exp_q.push_back(lat);
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            bus.ismultE = (c == 0 && m) || (c == lat && hold);
            bus.isdivE = c == 0 && d;
            bus.signedE = c == 0 ? s : !s;
            bus.divzeroE = c == 0 && dz;
            bus.flushE = c == fl;
            #1;
            chk("excl", bus.mulstart & bus.divstart, 0);
            if (bus.hilovalid) begin
                if (exp_q.size() > 0) chk("hilo_cycle", c, exp_q.pop_front());
                else chk("hilo_spurious", 1, 0);
            end
            if (c == 0) begin
                chk("mulstart", bus.mulstart, int'(m && !d));
                chk("divstart", bus.divstart, int'(d && !(DZ && dz)));
                chk("stall_acc", bus.stallmdE, 1);
                chk("busy_acc", bus.busy, 0);
            end else if (c == fl) begin
                chk("cancel", bus.cancel, 1);
                chk("stall_flush", bus.stallmdE, 0);
                chk("hilo_flush", bus.hilovalid, 0);
            end else if (fl > 0 && c > fl) begin
                chk("busy_after_flush", bus.busy, 0);
                chk("cancel_after_flush", bus.cancel, 0);
                break;
            end else if (c < lat) begin
                chk("stall", bus.stallmdE, 1);
                chk("busy", bus.busy, 1);
                chk("signedop", bus.signedop, s);
                chk("start_mid", bus.mulstart | bus.divstart, 0);
            end else if (c == lat) begin
                chk("stall_done", bus.stallmdE, 0);
                chk("hilovalid", bus.hilovalid, 1);
                chk("no_restart", bus.mulstart | bus.divstart, 0);
                chk("busy_done", bus.busy, 1);
            end else begin
                chk("busy_idle", bus.busy, 0);
                chk("hilo_idle", bus.hilovalid, 0);
            end
        end
        if (exp_q.size() != 0) begin
            chk("hilo_missing", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        idle_inputs();
    endtask
    initial begin
        idle_inputs();
        bus.ismultE = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        @(posedge clk);
        #2;
        bus.ismultE = 0;
        rst = 1;
        run_op(1, 0, 1, 0, -1, 0);
        run_op(0, 1, 0, 0, -1, 0);
        run_op(0, 1, 1, 0, 10, 0);
        run_op(1, 1, 1, 0, -1, 1);
        run_op(0, 1, 0, 1, -1, 0);
        run_op(1, 0, 0, 0, MUL_LAT, 0);
        @(negedge clk);
        bus.ismultE = 1;
        bus.flushE = 1;
        #1;
        chk("flush_idle_start", bus.mulstart, 0);
        chk("flush_idle_stall", bus.stallmdE, 0);
        chk("flush_idle_cancel", bus.cancel, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flush_idle_busy", bus.busy, 0);
        @(negedge clk);
        bus.isdivE = 1;
        bus.signedE = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            idle_inputs();
        end
        #1;
        chk("pre_reset_signed", bus.signedop, 1);
        bus.ismultE = 1;
        #1;
        rst = 0;
        #1;
        chk("async_reset_outs", outs(), 0);
        @(posedge clk);
        #2;
        chk("held_reset_outs", outs(), 0);
        bus.ismultE = 0;
        rst = 1;
        run_op(1, 0, 0, 0, -1, 0);
        for (int i = 0; i < 6; i++) begin
            bit m, d;
            m = 1'($urandom_range(0, 1));
            d = !m || 1'($urandom_range(0, 1));
            run_op(m, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
